// File: rtl/call_stack_lifo.sv
// Call-stack LIFO for the decoder: push/pop/replace, combinational top-of-stack, full/empty/count.
// Optional sticky overflow/underflow flags with err_clr when STACK_ERR_FLAGS_EN is defined.
module call_stack_lifo #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pushEn,
  input  logic              popEn,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              stackFull,
  output logic              stackEmpty,
`ifdef STACK_ERR_FLAGS_EN
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr,
`endif
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   sp;
  logic [ADDR_W:0]   sp_dec;
  logic [ADDR_W-1:0] top_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic              full;
  logic              empty;
  logic              do_push;
  logic              do_pop;
  logic              do_replace;

  assign full    = (sp == (ADDR_W+1)'(DEPTH));
  assign empty   = (sp == '0);
  assign sp_dec  = sp - 1'b1;
  assign top_idx = sp_dec[ADDR_W-1:0];

  // Push+pop on a non-empty stack overwrites the top; on an empty stack it is a plain push.
  assign do_replace = pushEn && popEn && !empty;
  assign do_push    = pushEn && !full && !do_replace;
  assign do_pop     = popEn && !pushEn && !empty;
  assign wr_idx     = do_replace ? top_idx : sp[ADDR_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + 1'b1;
    end else if (do_pop) begin
      sp <= sp_dec;
    end
  end

  // Storage is deliberately left unreset; sp alone defines which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push || do_replace) begin
      mem[wr_idx] <= data_in;
    end
  end

  assign data_out   = empty ? '0 : mem[top_idx];
  assign stackFull  = full;
  assign stackEmpty = empty;
  assign count      = sp;

`ifdef STACK_ERR_FLAGS_EN
  // A set condition on the same edge as err_clr takes priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (err_clr) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (pushEn && !popEn && full) begin
        overflow <= 1'b1;
      end
      if (popEn && !pushEn && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_call_stack_lifo.sv
// Bench for call_stack_lifo: queue-based reference model checked every cycle plus directed literal checks.
module tb_call_stack_lifo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pushEn = 1'b0;
  logic        popEn = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        stackFull;
  logic        stackEmpty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  logic [15:0] q[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  call_stack_lifo #(.WIDTH(16), .ADDR_W(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .pushEn     (pushEn),
    .popEn      (popEn),
    .data_in    (data_in),
    .data_out   (data_out),
    .stackFull  (stackFull),
    .stackEmpty (stackEmpty),
`ifdef STACK_ERR_FLAGS_EN
    .overflow   (overflow),
    .underflow  (underflow),
    .err_clr    (err_clr),
`endif
    .count      (count)
  );

`ifndef STACK_ERR_FLAGS_EN
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue, top at the back.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (err_clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (pushEn && popEn) begin
        if (q.size() == 0) q.push_back(data_in);
        else q[q.size()-1] = data_in;
      end else if (pushEn) begin
        if (q.size() < 8) q.push_back(data_in);
        else m_ovf = 1'b1;
      end else if (popEn) begin
        if (q.size() > 0) void'(q.pop_back());
        else m_unf = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_on) begin
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_data_out", 32'(data_out), (q.size() == 0) ? 32'h0 : 32'(q[q.size()-1]));
      chk("m_full", 32'(stackFull), 32'(q.size() == 8));
      chk("m_empty", 32'(stackEmpty), 32'(q.size() == 0));
`ifdef STACK_ERR_FLAGS_EN
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_underflow", 32'(underflow), 32'(m_unf));
`endif
    end
  end

  // Drive one cycle of inputs, return at the following negedge with inputs idled.
  task automatic cyc(input logic p, input logic o, input logic [15:0] d, input logic c = 1'b0);
    pushEn = p; popEn = o; data_in = d; err_clr = c;
    @(negedge clock);
    pushEn = 1'b0; popEn = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    // 1: reset state
    chk("rst_empty", 32'(stackEmpty), 32'h1);
    chk("rst_full", 32'(stackFull), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_unf", 32'(underflow), 32'h0);
    reset = 1'b0;
    cmp_on = 1'b1;
    @(negedge clock);

    // 2: push three, pop one
    cyc(1, 0, 16'h1111);
    chk("push1_latency", 32'(data_out), 32'h1111);
    cyc(1, 0, 16'h2222);
    cyc(1, 0, 16'h3333);
    chk("t2_count", 32'(count), 32'd3);
    chk("t2_data", 32'(data_out), 32'h3333);
    cyc(0, 1, 16'h0);
    chk("t2_pop_data", 32'(data_out), 32'h2222);
    chk("t2_pop_count", 32'(count), 32'd2);

    // 5: replace top, then pop reveals entry below
    cyc(1, 1, 16'hBEEF);
    chk("t5_count", 32'(count), 32'd2);
    chk("t5_data", 32'(data_out), 32'hBEEF);
    cyc(0, 1, 16'h0);
    chk("t5_below", 32'(data_out), 32'h1111);
    cyc(0, 1, 16'h0);

    // 4: pop on empty, then clear
    cyc(0, 1, 16'h0);
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_data", 32'(data_out), 32'h0);
`ifdef STACK_ERR_FLAGS_EN
    chk("t4_underflow", 32'(underflow), 32'h1);
    cyc(0, 0, 16'h0, 1'b1);
    chk("t4_clr", 32'(underflow), 32'h0);
    // Set beats clear on the same edge
    cyc(0, 1, 16'h0, 1'b1);
    chk("t4_set_wins", 32'(underflow), 32'h1);
    cyc(0, 0, 16'h0, 1'b1);
`endif

    // 3: fill, overflow attempt, replace on full
    for (int i = 1; i <= 8; i++) cyc(1, 0, 16'(i));
    chk("t3_full", 32'(stackFull), 32'h1);
    chk("t3_data", 32'(data_out), 32'h0008);
    cyc(1, 0, 16'hDEAD);
    chk("t3_ovf_count", 32'(count), 32'd8);
    chk("t3_ovf_data", 32'(data_out), 32'h0008);
`ifdef STACK_ERR_FLAGS_EN
    chk("t3_overflow", 32'(overflow), 32'h1);
    cyc(0, 0, 16'h0, 1'b1);
    chk("t3_clr", 32'(overflow), 32'h0);
`endif
    cyc(1, 1, 16'hCAFE);
    chk("full_replace", 32'(data_out), 32'hCAFE);
    repeat (7) cyc(0, 1, 16'h0);
    chk("drain_data", 32'(data_out), 32'h0001);
    cyc(0, 1, 16'h0);
    cyc(1, 1, 16'h0123);
    chk("empty_pp_push", 32'(count), 32'd1);
    chk("empty_pp_data", 32'(data_out), 32'h0123);

    // 6: async reset mid-cycle with count=5
    for (int i = 0; i < 4; i++) cyc(1, 0, 16'h0A00 + 16'(i));
    chk("t6_pre_count", 32'(count), 32'd5);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_empty", 32'(stackEmpty), 32'h1);
    chk("t6_async_count", 32'(count), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    cyc(1, 0, 16'h00AA);
    chk("t6_after", 32'(data_out), 32'h00AA);

    // Back-to-back mixed traffic against the model
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 7) == 0));

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
